// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Iterative 32-bit multiply / divide unit. It produces one radix-2 step per
// clock and delivers a result a fixed 33 cycles after start is accepted,
// whatever the operation or operand values.
//
// Ports
//   cclk   in   1   system clock, all state changes on the rising edge
//   rst    in   1   asynchronous, active-high reset
//   start  in   1   begin an operation (accepted only while not busy)
//   op     in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a      in  32   multiplicand / dividend
//   b      in  32   multiplier / divisor
//   busy   out  1   high while the operation is in progress (CALC, FIX)
//   done   out  1   one-cycle pulse marking a valid result (write strobe for
//                   the downstream HI/LO registers)
//   hi     out 32   product[63:32] or remainder
//   lo     out 32   product[31:0] or quotient
//   dbz    out  1   divide by zero, meaningful only while done is high
// ---------------------------------------------------------------------------
module mult_div_unit (
  input  logic        cclk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_mag_q, a_mag_d;
  logic [31:0] b_mag_q, b_mag_d;
  logic        a_neg_q, a_neg_d;
  logic        b_neg_q, b_neg_d;
  logic        bzero_q, bzero_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Operand magnitudes seen at the inputs. Signs only count for the signed
  // operations (op[0] = 1). Negating 32'h80000000 yields 32'h80000000, which
  // read as unsigned is exactly 2^31, so the magnitude path cannot overflow.
  logic        in_signed;
  logic        in_a_neg;
  logic        in_b_neg;
  logic [31:0] in_a_mag;
  logic [31:0] in_b_mag;

  always_comb begin
    in_signed = op[0];
    in_a_neg  = in_signed & a[31];
    in_b_neg  = in_signed & b[31];
    in_a_mag  = in_a_neg ? (~a + 32'd1) : a;
    in_b_mag  = in_b_neg ? (~b + 32'd1) : b;
  end

  // One iteration of each algorithm, computed from the accumulator.
  //
  // Multiply: acc[31:0] starts as the multiplier. Each step conditionally adds
  // the multiplicand into the upper half (33 bits to keep the carry), then the
  // whole 65-bit value shifts right by one. After 32 steps acc holds the
  // 64-bit product.
  //
  // Divide (restoring): acc[63:32] is the partial remainder and acc[31:0]
  // starts as the dividend. Each step shifts the next dividend bit into the
  // remainder, tries to subtract the divisor, keeps the difference when it
  // does not borrow, and shifts the quotient bit in at the bottom.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_mag_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_mag_q};
    if (!div_diff[33]) begin
      div_next = {div_diff[31:0], acc_q[30:0], 1'b1};
    end else begin
      div_next = {div_shift[31:0], acc_q[30:0], 1'b0};
    end
  end

  // Sign correction applied in FIX. Since a_neg/b_neg were only ever set for
  // the signed ops, the unsigned ops fall through with no correction.
  // The divide-by-zero result returns the original dividend on hi, rebuilt
  // from its magnitude and sign.
  logic        is_div;
  logic        res_neg;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] a_orig;

  always_comb begin
    is_div   = op_q[1];
    res_neg  = a_neg_q ^ b_neg_q;
    prod_fix = res_neg ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = res_neg ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = a_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    a_orig   = a_neg_q ? (~a_mag_q + 32'd1) : a_mag_q;
  end

  // Next-state and datapath update. IDLE and DONE behave the same way, which
  // is what lets a new start in the DONE cycle run back-to-back. start is
  // simply not looked at in CALC/FIX, so it cannot disturb a running op.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    bzero_d = bzero_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = 5'd0;
          op_d    = op;
          a_mag_d = in_a_mag;
          b_mag_d = in_b_mag;
          a_neg_d = in_a_neg;
          b_neg_d = in_b_neg;
          bzero_d = (b == 32'd0);
          // Multiply shifts the multiplier out of the low half; divide
          // shifts the dividend out of it.
          acc_d   = op[1] ? {32'd0, in_a_mag} : {32'd0, in_b_mag};
        end else begin
          state_d = IDLE;
        end
      end

      CALC: begin
        acc_d = is_div ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end
      end

      FIX: begin
        state_d = DONE;
        if (is_div) begin
          if (bzero_q) begin
            hi_d = a_orig;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every register clears on reset so an aborted operation leaves nothing
  // behind on hi/lo and the next start behaves as from power-up.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 2'd0;
      a_mag_q <= 32'd0;
      b_mag_q <= 32'd0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      bzero_q <= 1'b0;
      acc_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      bzero_q <= bzero_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // The operation registers are untouched during DONE, so dbz can be decoded
  // straight from them and is forced low outside the done cycle.
  always_comb begin
    busy = (state_q == CALC) || (state_q == FIX);
    done = (state_q == DONE);
    dbz  = (state_q == DONE) && is_div && bzero_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//
// Directed bench for mult_div_unit. A behavioural model tracks how many
// cycles have passed since an operation was accepted and computes results
// with plain arithmetic; a compare process checks every output against it on
// each falling edge. The main sequence also checks hand-computed literals.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  logic        cclk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .cclk  (cclk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .dbz   (dbz)
  );

  always #5 cclk = ~cclk;

  // Compare one value against its expectation and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {dbz, hi, lo}.
  function automatic logic [64:0] modelResult(input logic [1:0] o,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
    longint      sx, sy, sq, sr;
    logic [63:0] up;
    sx = $signed(x);
    sy = $signed(y);
    if (o == 2'b00) begin
      up = {32'd0, x} * {32'd0, y};
      return {1'b0, up};
    end else if (o == 2'b01) begin
      sq = sx * sy;
      up = sq;
      return {1'b0, up};
    end else if (y == 32'd0) begin
      return {1'b1, x, 32'hFFFF_FFFF};
    end else if (o == 2'b10) begin
      return {1'b0, x % y, x / y};
    end else begin
      sq = sx / sy;
      sr = sx % sy;
      return {1'b0, sr[31:0], sq[31:0]};
    end
  endfunction

  // Model timing: phase 0 idle, 1..33 busy, 34 the done cycle.
  int          phase   = 0;
  logic [31:0] exp_hi  = 32'd0;
  logic [31:0] exp_lo  = 32'd0;
  logic        exp_dzf = 1'b0;
  logic [1:0]  lat_op  = 2'd0;
  logic [31:0] lat_a   = 32'd0;
  logic [31:0] lat_b   = 32'd0;

  always @(posedge cclk or posedge rst) begin
    logic [64:0] r;
    if (rst) begin
      phase   = 0;
      exp_hi  = 32'd0;
      exp_lo  = 32'd0;
      exp_dzf = 1'b0;
    end else if (phase == 0 || phase == 34) begin
      if (start) begin
        lat_op = op;
        lat_a  = a;
        lat_b  = b;
        phase  = 1;
      end else begin
        phase = 0;
      end
    end else begin
      phase = phase + 1;
      if (phase == 34) begin
        r       = modelResult(lat_op, lat_a, lat_b);
        exp_dzf = r[64];
        exp_hi  = r[63:32];
        exp_lo  = r[31:0];
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge cclk) begin
    logic e_busy, e_done;
    e_busy = (phase >= 1) && (phase <= 33);
    e_done = (phase == 34);
    checkOutput("busy", {31'd0, busy}, {31'd0, e_busy});
    checkOutput("done", {31'd0, done}, {31'd0, e_done});
    checkOutput("dbz",  {31'd0, dbz},  {31'd0, e_done & exp_dzf});
    checkOutput("hi",   hi, exp_hi);
    checkOutput("lo",   lo, exp_lo);
  end

  // Present one operation; start is high across exactly one rising edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x,
                               input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(negedge cclk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; report cycles from start and busy cycles seen.
  task automatic waitDone(output int cyc, output int bcyc);
    cyc  = 0;
    bcyc = busy ? 1 : 0;
    while (cyc < 40) begin
      @(negedge cclk);
      cyc++;
      if (done) break;
      if (busy) bcyc++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout waiting for done actual=%0d cycles required=33", cyc);
    end
  endtask

  task automatic runOp(input string name, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] e_hi, input logic [31:0] e_lo,
                       input logic e_dbz);
    int cyc, bcyc;
    applyStimulus(o, x, y);
    waitDone(cyc, bcyc);
    checkOutput({name, "_latency"}, 32'(cyc), 32'd33);
    checkOutput({name, "_hi"}, hi, e_hi);
    checkOutput({name, "_lo"}, lo, e_lo);
    checkOutput({name, "_dbz"}, {31'd0, dbz}, {31'd0, e_dbz});
    @(negedge cclk);
    checkOutput({name, "_dbz_after"}, {31'd0, dbz}, 32'd0);
  endtask

  initial begin
    int cyc, bcyc;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    a     = 32'd0;
    b     = 32'd0;
    @(negedge cclk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    @(negedge cclk);
    rst = 1'b0;
    @(negedge cclk);

    // MULTU all-ones, with latency and busy-length checks.
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(cyc, bcyc);
    checkOutput("multu_latency", 32'(cyc), 32'd33);
    checkOutput("multu_busy_cycles", 32'(bcyc), 32'd33);
    checkOutput("multu_hi", hi, 32'hFFFF_FFFE);
    checkOutput("multu_lo", lo, 32'h0000_0001);
    @(negedge cclk);

    runOp("mult_neg3x7",  2'b01, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    runOp("div_neg7by2",  2'b11, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    runOp("div_minbym1",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0);
    runOp("divu_5by0",    2'b10, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1);
    runOp("div_7byneg2",  2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0);
    runOp("div_neg5by0",  2'b11, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    runOp("mult_minsq",   2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0);
    runOp("mult_minx1",   2'b01, 32'h8000_0000, 32'd1,        32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    runOp("divu_max3",    2'b10, 32'hFFFF_FFFF, 32'd3,        32'd0,         32'h5555_5555, 1'b0);
    runOp("multu_minx2",  2'b00, 32'h8000_0000, 32'd2,        32'd1,         32'd0,        1'b0);

    // Reset in the middle of DIVU 100/7 aborts it without any result.
    applyStimulus(2'b10, 32'd100, 32'd7);
    repeat (9) @(negedge cclk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    @(negedge cclk);
    rst = 1'b0;
    repeat (2) @(negedge cclk);
    runOp("multu_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    // start while busy is ignored; start in the done cycle is accepted.
    applyStimulus(2'b00, 32'd2, 32'd3);
    repeat (4) @(negedge cclk);
    applyStimulus(2'b00, 32'd9, 32'd9);
    waitDone(cyc, bcyc);
    checkOutput("ignored_lo", lo, 32'd6);
    checkOutput("ignored_hi", hi, 32'd0);
    applyStimulus(2'b00, 32'd9, 32'd9);
    waitDone(cyc, bcyc);
    checkOutput("b2b_latency", 32'(cyc), 32'd33);
    checkOutput("b2b_lo", lo, 32'd81);
    repeat (3) @(negedge cclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 The block SHALL have the following ports:
cclk  input  1  single system clock; all state changes on its rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request to begin an operation; sampled on rising cclk
op  input  2  operation code: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  32  multiplicand or dividend
b  input  32  multiplier or divisor
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse that marks a valid result; drives the write input of the downstream HI/LO registers
hi  output  32  product[63:32] or remainder; feeds the HI register data_in
lo  output  32  product[31:0] or quotient; feeds the LO register data_in
dbz  output  1  divide-by-zero flag; valid only while done is high

Function
REQ-003 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-004 IDLE or DONE with start=1 at edge N: the block SHALL latch op, |a| and |b|, the operand signs and b==0; clear the iteration counter; and enter CALC.
REQ-005 IDLE or DONE with start=0: the block SHALL go to or stay in IDLE.
REQ-006 CALC SHALL perform one radix-2 iteration per cycle for exactly 32 cycles, at edges N+1 to N+32, then enter FIX.
REQ-007 Multiply iteration: unsigned shift-add on the 32-bit magnitudes, giving a 64-bit unsigned product.
REQ-008 Divide iteration: restoring shift-subtract, giving a 32-bit unsigned quotient and remainder.
REQ-009 FIX SHALL apply the sign correction for MULT and DIV, load hi and lo, and enter DONE at edge N+33.
REQ-010 MULT sign rule: the 64-bit product SHALL be two's-complement negated if and only if the operand signs differ.
REQ-011 DIV sign rule: the quotient SHALL be negated if and only if the operand signs differ; the remainder SHALL take the sign of the dividend.
REQ-012 MULTU and DIVU SHALL apply no sign correction.
REQ-013 Latency: done SHALL be high for exactly one cycle, from edge N+33 to edge N+34, i.e. 33 cycles after start is sampled, independent of op and operand values.
REQ-014 busy SHALL be 1 in CALC and FIX and 0 in IDLE and DONE.
REQ-015 start while busy=1 SHALL be ignored: no operand resample and no timing change.
REQ-016 start during the DONE cycle SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-017 hi and lo SHALL change only at the FIX to DONE transition and hold their value until the next such transition or reset.
REQ-018 Divide by zero (DIVU or DIV with b=0): the block SHALL produce lo=32'hFFFFFFFF, hi=a (original dividend, unsigned view) and dbz=1 with done, at the same latency.
REQ-019 dbz SHALL be 0 whenever done=0, and 0 for all multiply operations.
REQ-020 DIV 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0, with no error flag.
REQ-021 Magnitude of 32'h80000000 SHALL be treated as unsigned 2^31; there SHALL be no overflow in the magnitude path.

Reset
REQ-022 While rst=1, asynchronously and regardless of cclk: state=IDLE, counter=0, busy=0, done=0, dbz=0, hi=0, lo=0, and all internal operand and accumulator registers SHALL be 0.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no done pulse and no partial result visible on hi or lo.
REQ-024 After rst deasserts, the first start sampled SHALL behave exactly as from IDLE.

Verification
REQ-025 MULTU a=32'hFFFFFFFF b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001; done exactly 33 cycles after start; busy high for 32+1 cycles.
REQ-026 MULT a=-3 (32'hFFFFFFFD) b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; dbz=0.
REQ-027 DIV a=-7 b=2 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1); also DIV 32'h80000000 / -1 -> lo=32'h80000000, hi=0.
REQ-028 DIVU a=5 b=0 -> lo=32'hFFFFFFFF, hi=5, dbz=1 during the done cycle; dbz=0 in the next cycle.
REQ-029 DIVU 100/7 started, rst pulsed at cycle 10 -> busy, done, hi, lo all 0 immediately with no done pulse; then MULTU 6*7 -> lo=42, hi=0 after 33 cycles.
REQ-030 MULTU 2*3 started, start re-pulsed with 9*9 while busy -> result lo=6; start asserted in the done cycle with 9*9 -> lo=81 exactly 33 cycles later.
